// File: rtl/field_vga_scan.sv
// VGA raster reader for a 20x20 playfield: registered syncs/colour, snapshot latched at vblank start.
// Optional macro FIELD_GRID_EN overlays 12'h444 grid lines on cell borders and the outer field edge.
module field_vga_scan #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CELL_PX  = 16,
    parameter int X_OFF    = 160,
    parameter int Y_OFF    = 80
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [399:0] field_display,
    output logic         hsync,
    output logic         vsync,
    output logic [11:0]  rgb,
    output logic         frame_tick
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int FIELD_W  = 20 * CELL_PX;
    localparam int CELL_SH  = $clog2(CELL_PX);
    localparam bit CELL_POW2 = ((1 << CELL_SH) == CELL_PX);

    if (X_OFF + FIELD_W > H_ACTIVE || Y_OFF + FIELD_W > V_ACTIVE) begin : g_fit_check
        $error("field_vga_scan: 20x20 field does not fit inside the active area");
    end

    logic [HW-1:0]  h_q, h_d;
    logic [VW-1:0]  v_q, v_d;
    logic [399:0]   snap_q;
    logic           hsync_q, vsync_q, tick_q;
    logic [11:0]    rgb_q, pix_d;
    logic           h_wrap, active, in_field, snap_load, cell_on;
    logic [4:0]     col, row;
    logic [8:0]     cell_idx;
`ifdef FIELD_GRID_EN
    logic           grid_x, grid_y, in_box, on_grid;
`endif

    always_comb begin
        h_wrap = (h_q == HW'(H_TOTAL - 1));
        h_d    = h_wrap ? '0 : h_q + 1'b1;
        v_d    = v_q;
        if (h_wrap) begin
            v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
        end
    end

    // Cell coordinates: plain shift for power-of-two cells, running sub-counters otherwise.
    if (CELL_POW2) begin : g_shift
        logic [HW-1:0] rel_x;
        logic [VW-1:0] rel_y;
        assign rel_x = h_q - HW'(X_OFF);
        assign rel_y = v_q - VW'(Y_OFF);
        assign col   = 5'(rel_x >> CELL_SH);
        assign row   = 5'(rel_y >> CELL_SH);
`ifdef FIELD_GRID_EN
        assign grid_x = ((rel_x & HW'(CELL_PX - 1)) == '0);
        assign grid_y = ((rel_y & VW'(CELL_PX - 1)) == '0);
`endif
    end else begin : g_subcnt
        localparam int CW = $clog2(CELL_PX);
        logic [CW-1:0] cx_q, cy_q;
        logic [4:0]    col_q, row_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cx_q  <= '0;
                cy_q  <= '0;
                col_q <= '0;
                row_q <= '0;
            end else begin
                if (h_d == HW'(X_OFF)) begin
                    cx_q  <= '0;
                    col_q <= '0;
                end else if (cx_q == CW'(CELL_PX - 1)) begin
                    cx_q  <= '0;
                    col_q <= col_q + 1'b1;
                end else begin
                    cx_q  <= cx_q + 1'b1;
                end
                if (h_wrap) begin
                    if (v_d == VW'(Y_OFF)) begin
                        cy_q  <= '0;
                        row_q <= '0;
                    end else if (cy_q == CW'(CELL_PX - 1)) begin
                        cy_q  <= '0;
                        row_q <= row_q + 1'b1;
                    end else begin
                        cy_q  <= cy_q + 1'b1;
                    end
                end
            end
        end

        assign col = col_q;
        assign row = row_q;
`ifdef FIELD_GRID_EN
        assign grid_x = (cx_q == '0);
        assign grid_y = (cy_q == '0);
`endif
    end

`ifdef FIELD_GRID_EN
    // The box includes one extra pixel column/row so the far field edge gets its closing line.
    assign in_box  = (h_q >= HW'(X_OFF)) && (h_q <= HW'(X_OFF + FIELD_W)) &&
                     (v_q >= VW'(Y_OFF)) && (v_q <= VW'(Y_OFF + FIELD_W));
    assign on_grid = (in_field && (grid_x || grid_y)) ||
                     (in_box && ((h_q == HW'(X_OFF + FIELD_W)) || (v_q == VW'(Y_OFF + FIELD_W))));
`endif

    always_comb begin
        active    = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
        in_field  = (h_q >= HW'(X_OFF)) && (h_q < HW'(X_OFF + FIELD_W)) &&
                    (v_q >= VW'(Y_OFF)) && (v_q < VW'(Y_OFF + FIELD_W));
        cell_idx  = 9'(row) * 9'd20 + 9'(col);
        cell_on   = snap_q[cell_idx];
        snap_load = (h_q == '0) && (v_q == VW'(V_ACTIVE));
        pix_d     = 12'h000;
        if (active) begin
            pix_d = 12'h222;
            if (in_field) begin
                pix_d = cell_on ? 12'h0F0 : 12'h000;
            end
`ifdef FIELD_GRID_EN
            if (on_grid) begin
                pix_d = 12'h444;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            snap_q  <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= 12'h000;
            tick_q  <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= !((h_q >= HW'(HS_START)) && (h_q < HW'(HS_END)));
            vsync_q <= !((v_q >= VW'(VS_START)) && (v_q < VW'(VS_END)));
            rgb_q   <= pix_d;
            tick_q  <= snap_load;
            if (snap_load) begin
                snap_q <= field_display;
            end
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign rgb        = rgb_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_field_vga_scan.sv
// Scoreboard bench for field_vga_scan on a scaled-down raster (112x103 total, 4-px cells).
module tb_field_vga_scan;
    localparam int HA = 96, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 96, VFP = 2, VS = 2, VBP = 3;
    localparam int CP = 4, XO = 8, YO = 8;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
`ifdef FIELD_GRID_EN
    localparam bit GRID = 1'b1;
`else
    localparam bit GRID = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [399:0] fd = '0;
    logic         hsync, vsync, frame_tick;
    logic [11:0]  rgb;

    always #5 clk = ~clk;

    field_vga_scan #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .CELL_PX(CP), .X_OFF(XO), .Y_OFF(YO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .field_display(fd),
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_tick(frame_tick)
    );

    typedef struct { int f; int h; int v; logic hs; logic vs; logic [11:0] rgb; logic tick; } exp_t;
    typedef struct { int f; int h; int v; logic [11:0] rgb; } pt_t;

    exp_t         exp_q[$];
    pt_t          pt_q[$];
    int           n_chk = 0, n_pass = 0;
    bit           mon_en = 1'b0;
    int           mh = 0, mv = 0, mfrm = 0;
    logic [399:0] msnap = '0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endfunction

    function automatic logic [11:0] model_rgb(int h, int v, logic [399:0] s);
        int fx = h - XO;
        int fy = v - YO;
        int fw = 20 * CP;
        if (h >= HA || v >= VA) return 12'h000;
        if (GRID && fx >= 0 && fy >= 0 && fx <= fw && fy <= fw &&
            (fx % CP == 0 || fy % CP == 0 || fx == fw || fy == fw)) return 12'h444;
        if (fx >= 0 && fy >= 0 && fx < fw && fy < fw)
            return s[(fy / CP) * 20 + fx / CP] ? 12'h0F0 : 12'h000;
        return 12'h222;
    endfunction

    function automatic void add_pt(int f, int h, int v, logic [11:0] c);
        pt_t p;
        p.f = f; p.h = h; p.v = v; p.rgb = c;
        pt_q.push_back(p);
    endfunction

    // Predictor: expected registered outputs for the current raster position.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mh = 0; mv = 0; msnap = '0;
            exp_q.delete();
        end else begin
            exp_t e;
            e.f    = mfrm; e.h = mh; e.v = mv;
            e.hs   = !(mh >= HA + HFP && mh < HA + HFP + HS);
            e.vs   = !(mv >= VA + VFP && mv < VA + VFP + VS);
            e.rgb  = model_rgb(mh, mv, msnap);
            e.tick = (mh == 0 && mv == VA);
            exp_q.push_back(e);
            if (e.tick) begin
                msnap = fd;
                mfrm++;
            end
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
    end

    // Monitor: one popped expectation per clock, plus hand-computed pixel points.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n || exp_q.size() == 0) begin
                chk("reset_outputs", 32'({hsync, vsync, rgb, frame_tick}), 32'({1'b1, 1'b1, 12'h000, 1'b0}));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("out f%0d h%0d v%0d {hs,vs,rgb,tick}", e.f, e.h, e.v),
                    32'({hsync, vsync, rgb, frame_tick}), 32'({e.hs, e.vs, e.rgb, e.tick}));
                if (pt_q.size() > 0 && pt_q[0].f == e.f && pt_q[0].h == e.h && pt_q[0].v == e.v) begin
                    chk($sformatf("point f%0d (%0d,%0d) rgb", e.f, e.h, e.v), 32'(rgb), 32'(pt_q[0].rgb));
                    void'(pt_q.pop_front());
                end
            end
        end
    end

    task automatic wait_coord(int f, int h, int v);
        int n = 0;
        while (!(mfrm == f && mh == h && mv == v) && n < 40000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("reach f%0d (%0d,%0d)", f, h, v), 32'(mfrm == f && mh == h && mv == v), 32'd1);
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        #1 mon_en = 1'b1;
        chk("reset hsync", 32'(hsync), 32'd1);
        chk("reset vsync", 32'(vsync), 32'd1);
        chk("reset rgb", 32'(rgb), 32'h000);
        chk("reset frame_tick", 32'(frame_tick), 32'd0);

        // Frame 1: only cell(0,0) set. Frame 2: only cell(19,19) set.
        add_pt(1, 7, 8, 12'h222);
        add_pt(1, 8, 8, GRID ? 12'h444 : 12'h0F0);
        add_pt(1, 9, 9, 12'h0F0);
        add_pt(1, 13, 9, 12'h000);
        add_pt(1, 88, 10, GRID ? 12'h444 : 12'h222);
        add_pt(1, 11, 11, 12'h0F0);
        add_pt(1, 85, 85, 12'h000);
        add_pt(2, 9, 9, 12'h000);
        add_pt(2, 83, 85, 12'h000);
        add_pt(2, 85, 85, 12'h0F0);
        add_pt(2, 88, 85, GRID ? 12'h444 : 12'h222);
        add_pt(2, 87, 87, 12'h0F0);
        add_pt(3, 9, 9, 12'h000);
        add_pt(4, 85, 85, 12'h0F0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        fd[0] = 1'b1;

        wait_coord(1, 0, 50);
        fd[0]   = 1'b0;
        fd[399] = 1'b1;

        wait_coord(3, 102, 98);
        chk("pre-reset hsync low", 32'(hsync), 32'd0);
        chk("pre-reset vsync low", 32'(vsync), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async reset hsync", 32'(hsync), 32'd1);
        chk("async reset vsync", 32'(vsync), 32'd1);
        chk("async reset rgb", 32'(rgb), 32'h000);
        chk("async reset frame_tick", 32'(frame_tick), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 100 counts to the sync start plus one output register stage.
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (hsync && n < 1000);
        chk("first hsync low after release (clk)", 32'(n), 32'd101);

        n = 0;
        while (pt_q.size() > 0 && n < 40000) begin
            @(posedge clk);
            n++;
        end
        chk("pixel points left unvisited", 32'(pt_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
